// File: rtl/clk_pkg.sv
// Shared definitions for the clock-datapath BCD counters.
//   BCD_W   : width of one BCD digit
//   to_bcd  : integer -> BCD vector (up to 4 digits, unused digits zero)
//   bcd_lt  : decimal value of a BCD vector compared against a limit
package clk_pkg;

  localparam int BCD_W   = 4;
  localparam int MAX_DIG = 4;

  function automatic logic [BCD_W*MAX_DIG-1:0] to_bcd(int value, int ndig);
    logic [BCD_W*MAX_DIG-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (i < ndig) begin
        r[BCD_W*i +: BCD_W] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  // Digits above 9 are not screened here; callers combine this with a digit check.
  function automatic logic bcd_lt(logic [BCD_W*MAX_DIG-1:0] v, int lim);
    int acc;
    acc = 0;
    for (int i = MAX_DIG - 1; i >= 0; i--)
      acc = acc * 10 + int'(v[BCD_W*i +: BCD_W]);
    return acc < lim;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/data bundle of one BCD modulo counter.
//   master : drives CLR, LD, DIN, EN, INC, DOWN; observes Q, CO, LDERR
//   slave  : the counter itself
interface bcd_mod_counter_if #(parameter int NDIG = 2);
  logic                CLR;
  logic                LD;
  logic [4*NDIG-1:0]   DIN;
  logic                EN;
  logic                INC;
  logic                DOWN;
  logic [4*NDIG-1:0]   Q;
  logic                CO;
  logic                LDERR;

  modport master (output CLR, LD, DIN, EN, INC, DOWN, input Q, CO, LDERR);
  modport slave  (input CLR, LD, DIN, EN, INC, DOWN, output Q, CO, LDERR);
endinterface

// File: rtl/bcd_mod_counter_digit.sv
// One BCD digit of the ripple counter.
//   step_in    : carry/borrow from the lower digit (or the top-level step)
//   down       : direction, 1 = decrement
//   force_zero : load 0 (clear / up-wrap), wins over force_val
//   force_val  : load val (parallel load / down-wrap)
//   digit      : registered digit value
//   step_out   : ripple carry (9->0) or borrow (0->9) to the next digit
module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_in,
  input  logic       down,
  input  logic       force_zero,
  input  logic       force_val,
  input  logic [3:0] val,
  output logic [3:0] digit,
  output logic       step_out
);

  assign step_out = step_in & (down ? (digit == 4'd0) : (digit == 4'd9));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          digit <= 4'd0;
    else if (force_zero) digit <= 4'd0;
    else if (force_val)  digit <= val;
    else if (step_in) begin
      if (down) digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      else      digit <= (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter, up/down, with checked parallel load.
//   CLK, RST_N : clock, async active-low reset
//   bus        : slave side of bcd_mod_counter_if
//                CLR > LD > (EN|INC) > hold; CO is combinational terminal count,
//                LDERR a one-cycle pulse after a rejected load.
module bcd_mod_counter
  import clk_pkg::*;
#(
  parameter int NDIG   = 2,
  parameter int MODULO = 60
) (
  input  logic               CLK,
  input  logic               RST_N,
  bcd_mod_counter_if.slave   bus
);

  localparam int W = BCD_W * NDIG;
  localparam logic [BCD_W*MAX_DIG-1:0] TERM_X = to_bcd(MODULO - 1, NDIG);
  localparam logic [W-1:0] TERM = TERM_X[W-1:0];

  generate
    if (NDIG < 1 || NDIG > MAX_DIG || MODULO < 2 || MODULO > 10**NDIG) begin : g_bad_param
      $error("bcd_mod_counter: illegal NDIG/MODULO combination");
    end
  endgenerate

  logic [NDIG-1:0][3:0] dig;
  logic [W-1:0]         q;
  logic [W-1:0]         fval;
  logic [NDIG:0]        carry;
  logic step, adv, legal, q_ok, at_term, at_zero;
  logic wrap_up, wrap_dn, force_zero, force_en;
  logic lderr;

  assign q = dig;

  // Load legality and a sanity check on the current state (the latter only
  // matters if an out-of-range value is ever reached).
  always_comb begin
    legal = bcd_lt(16'(bus.DIN), MODULO);
    q_ok  = bcd_lt(16'(q), MODULO);
    for (int i = 0; i < NDIG; i++) begin
      if (bus.DIN[4*i +: 4] > 4'd9) legal = 1'b0;
      if (q[4*i +: 4] > 4'd9)       q_ok  = 1'b0;
    end
  end

  assign step    = bus.EN | bus.INC;
  assign adv     = step & ~bus.CLR & ~bus.LD;
  assign at_term = (q == TERM);
  assign at_zero = (q == '0);

  // Wraps bypass the ripple chain and are loaded directly via the force inputs.
  assign wrap_up    = adv & ~bus.DOWN & (at_term | ~q_ok);
  assign wrap_dn    = adv &  bus.DOWN & (at_zero | ~q_ok);
  assign force_zero = bus.CLR | wrap_up;
  assign force_en   = (bus.LD & legal) | wrap_dn;
  assign fval       = bus.LD ? bus.DIN : TERM;
  assign carry[0]   = adv & ~wrap_up & ~wrap_dn;

  genvar i;
  generate
    for (i = 0; i < NDIG; i++) begin : g_dig
      bcd_digit u_dig (
        .clk        (CLK),
        .rst_n      (RST_N),
        .step_in    (carry[i]),
        .down       (bus.DOWN),
        .force_zero (force_zero),
        .force_val  (force_en),
        .val        (fval[4*i +: 4]),
        .digit      (dig[i]),
        .step_out   (carry[i+1])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       lderr <= 1'b0;
    else if (bus.CLR) lderr <= 1'b0;
    else if (bus.LD)  lderr <= ~legal;
    else              lderr <= 1'b0;
  end

  assign bus.Q     = q;
  assign bus.LDERR = lderr;
  assign bus.CO    = adv & ((~bus.DOWN & at_term) | (bus.DOWN & at_zero));

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errs   = 0;

  always #5 clk = ~clk;

  bcd_mod_counter_if #(.NDIG(2)) b60();
  bcd_mod_counter_if #(.NDIG(2)) b24();
  bcd_mod_counter_if #(.NDIG(3)) b1k();

  bcd_mod_counter #(.NDIG(2), .MODULO(60))   u60 (.CLK(clk), .RST_N(rst_n), .bus(b60));
  bcd_mod_counter #(.NDIG(2), .MODULO(24))   u24 (.CLK(clk), .RST_N(rst_n), .bus(b24));
  bcd_mod_counter #(.NDIG(3), .MODULO(1000)) u1k (.CLK(clk), .RST_N(rst_n), .bus(b1k));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] bcd(input int k);
    return 32'(((k / 100) << 8) | (((k / 10) % 10) << 4) | (k % 10));
  endfunction

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {b60.CLR, b60.LD, b60.EN, b60.INC, b60.DOWN} = '0; b60.DIN = '0;
    {b24.CLR, b24.LD, b24.EN, b24.INC, b24.DOWN} = '0; b24.DIN = '0;
    {b1k.CLR, b1k.LD, b1k.EN, b1k.INC, b1k.DOWN} = '0; b1k.DIN = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_q",     b60.Q,     32'h0);
    chk("rst_lderr", b60.LDERR, 32'h0);
    chk("rst_co",    b60.CO,    32'h0);
    tick();
    rst_n = 1'b1;

    // Full up count 00..59 and wrap
    b60.EN = 1'b1;
    #1;
    for (int k = 0; k < 60; k++) begin
      chk("up60_q",  b60.Q,  bcd(k));
      chk("up60_co", b60.CO, (k == 59) ? 32'h1 : 32'h0);
      tick();
    end
    chk("up60_wrap", b60.Q, 32'h0);
    b60.EN = 1'b0;

    // Down count mod 24 from 00
    b24.DOWN = 1'b1; b24.EN = 1'b1;
    #1;
    chk("dn24_q0",  b24.Q,  32'h0);
    chk("dn24_co0", b24.CO, 32'h1);
    tick();
    for (int v = 23; v >= 9; v--) begin
      chk("dn24_q",  b24.Q,  bcd(v));
      chk("dn24_co", b24.CO, 32'h0);
      if (v > 9) tick();
    end
    b24.EN = 1'b0; b24.DOWN = 1'b0;

    // Loads: legal, out of range, non-BCD digit
    b60.LD = 1'b1; b60.DIN = 8'h45;
    tick();
    b60.LD = 1'b0;
    chk("ld45_q",     b60.Q,     32'h45);
    chk("ld45_lderr", b60.LDERR, 32'h0);
    b60.LD = 1'b1; b60.DIN = 8'h60;
    tick();
    b60.LD = 1'b0;
    chk("ld60_q",     b60.Q,     32'h45);
    chk("ld60_lderr", b60.LDERR, 32'h1);
    tick();
    chk("ld60_pulse", b60.LDERR, 32'h0);
    b60.LD = 1'b1; b60.DIN = 8'h3A;
    tick();
    b60.LD = 1'b0;
    chk("ld3a_q",     b60.Q,     32'h45);
    chk("ld3a_lderr", b60.LDERR, 32'h1);
    tick();
    chk("ld3a_pulse", b60.LDERR, 32'h0);

    // Priorities
    b60.LD = 1'b1; b60.DIN = 8'h37;
    tick();
    b60.LD = 1'b0; b60.EN = 1'b1; b60.INC = 1'b1;
    tick();
    b60.EN = 1'b0; b60.INC = 1'b0;
    chk("en_inc_once", b60.Q, 32'h38);
    b60.LD = 1'b1; b60.DIN = 8'h59;
    tick();
    b60.CLR = 1'b1; b60.LD = 1'b1; b60.EN = 1'b1; b60.DIN = 8'h12;
    #1;
    chk("clr_co", b60.CO, 32'h0);
    tick();
    b60.CLR = 1'b0; b60.LD = 1'b0; b60.EN = 1'b0;
    chk("clr_prio", b60.Q, 32'h0);
    b60.LD = 1'b1; b60.DIN = 8'h59;
    tick();
    b60.DIN = 8'h12; b60.EN = 1'b1;
    #1;
    chk("ld_en_co", b60.CO, 32'h0);
    tick();
    b60.LD = 1'b0; b60.EN = 1'b0;
    chk("ld_prio", b60.Q, 32'h12);

    // Asynchronous reset mid-cycle with a pending LDERR
    b60.LD = 1'b1; b60.DIN = 8'h52;
    tick();
    b60.DIN = 8'h99;
    tick();
    b60.LD = 1'b0;
    chk("pre_rst_q",     b60.Q,     32'h52);
    chk("pre_rst_lderr", b60.LDERR, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q",     b60.Q,     32'h0);
    chk("arst_lderr", b60.LDERR, 32'h0);
    tick();
    rst_n = 1'b1;
    b60.EN = 1'b1;
    tick();
    b60.EN = 1'b0;
    chk("post_rst", b60.Q, 32'h01);

    // Three digits, full modulus
    b1k.LD = 1'b1; b1k.DIN = 12'h999;
    tick();
    b1k.LD = 1'b0; b1k.EN = 1'b1;
    #1;
    chk("k999_co", b1k.CO, 32'h1);
    tick();
    b1k.EN = 1'b0;
    chk("k999_wrap", b1k.Q, 32'h000);
    b1k.LD = 1'b1; b1k.DIN = 12'h100;
    tick();
    b1k.LD = 1'b0; b1k.DOWN = 1'b1; b1k.EN = 1'b1;
    #1;
    chk("k100_co", b1k.CO, 32'h0);
    tick();
    b1k.EN = 1'b0;
    chk("k100_dn", b1k.Q, 32'h099);
    b1k.LD = 1'b1; b1k.DIN = 12'hA00;
    tick();
    b1k.LD = 1'b0;
    chk("ka00_q",     b1k.Q,     32'h099);
    chk("ka00_lderr", b1k.LDERR, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
